// File: rtl/oam_dma.sv
// oam_dma: Game Boy OAM DMA engine that snoops CPU writes to the DMA register
// and copies LENGTH bytes from page {src,00} into OAM as a second bus master.
module oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
    parameter logic [15:0] OAM_BASE     = 16'hFE00,
    parameter int          LENGTH       = 160,
    parameter int          START_DELAY  = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_wren,
    input  logic [7:0]  cpu_data_out,
    input  logic [7:0]  dma_data_in,
    output logic [7:0]  dma_reg_data,
    output logic        dma_active,
    output logic [15:0] dma_addr,
    output logic        dma_wren,
    output logic [7:0]  dma_data_out
);
    typedef enum logic [1:0] {IDLE, START, READ, WRITE} state_t;

    state_t      r_state, w_next;
    logic [7:0]  r_idx, r_src_page, r_data, r_reg, w_page;
    logic [1:0]  r_dly;
    logic        w_trig, w_last, w_dly_done;

    assign w_trig     = cpu_wren && (cpu_addr == DMA_REG_ADDR);
    // Pages E0..FF mirror C0..DF (echo RAM)
    assign w_page     = (r_src_page >= 8'hE0) ? r_src_page - 8'h20 : r_src_page;
    assign w_last     = r_idx == 8'(LENGTH - 1);
    assign w_dly_done = r_dly == 2'(START_DELAY - 1);
    assign dma_reg_data = r_reg;

    always_comb begin
        w_next       = r_state;
        dma_active   = 1'b0;
        dma_wren     = 1'b0;
        dma_addr     = '0;
        dma_data_out = '0;
        case (r_state)
            START: begin
                dma_active = 1'b1;
                w_next     = w_dly_done ? READ : START;
            end
            READ: begin
                dma_active = 1'b1;
                dma_addr   = {w_page, 8'h00} + {8'h00, r_idx};
                w_next     = WRITE;
            end
            WRITE: begin
                dma_active   = 1'b1;
                dma_wren     = 1'b1;
                dma_addr     = OAM_BASE + {8'h00, r_idx};
                dma_data_out = r_data;
                w_next       = w_last ? IDLE : READ;
            end
            default: w_next = IDLE;
        endcase
        // A retrigger overrides whatever transition the FSM wanted this edge
        if (w_trig) w_next = (START_DELAY == 0) ? READ : START;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_src_page <= '0;
            r_data     <= '0;
            r_reg      <= '0;
            r_dly      <= '0;
        end else begin
            r_state <= w_next;
            if (w_trig) begin
                r_src_page <= cpu_data_out;
                r_reg      <= cpu_data_out;
                r_idx      <= '0;
                r_dly      <= '0;
            end else begin
                if (r_state == START) r_dly <= r_dly + 2'd1;
                if (r_state == READ) r_data <= dma_data_in;
                if (r_state == WRITE && !w_last) r_idx <= r_idx + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: scoreboard bench for oam_dma; expected bus cycles are queued
// when a transfer is triggered and popped as the engine drives the bus.
module tb_oam_dma;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] cpu_addr = '0;
    logic        cpu_wren = 1'b0;
    logic        c2_wren = 1'b0;
    logic [7:0]  cpu_data_out = '0;
    logic [7:0]  dma_data_in, dma_reg_data, dma_data_out;
    logic        dma_active, dma_wren;
    logic [15:0] dma_addr;
    logic [7:0]  d2_in, d2_reg, d2_dout;
    logic        d2_act, d2_wren;
    logic [15:0] d2_addr;

    logic [7:0] mem [0:65535];
    logic [7:0] oam [0:255];

    typedef struct {
        logic [15:0] addr;
        logic        wren;
        logic [7:0]  data;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_fail = 0;

    oam_dma dut (
        .clock(clock), .reset(reset), .cpu_addr(cpu_addr), .cpu_wren(cpu_wren),
        .cpu_data_out(cpu_data_out), .dma_data_in(dma_data_in),
        .dma_reg_data(dma_reg_data), .dma_active(dma_active), .dma_addr(dma_addr),
        .dma_wren(dma_wren), .dma_data_out(dma_data_out)
    );

    oam_dma #(.LENGTH(1), .START_DELAY(0)) dut2 (
        .clock(clock), .reset(reset), .cpu_addr(cpu_addr), .cpu_wren(c2_wren),
        .cpu_data_out(cpu_data_out), .dma_data_in(d2_in),
        .dma_reg_data(d2_reg), .dma_active(d2_act), .dma_addr(d2_addr),
        .dma_wren(d2_wren), .dma_data_out(d2_dout)
    );

    always #5 clock = ~clock;

    assign dma_data_in = mem[dma_addr];
    assign d2_in = d2_addr[7:0] ^ d2_addr[15:8] ^ 8'h33;

    always @(posedge clock)
        if (dma_wren && dma_addr[15:8] == 8'hFE) oam[dma_addr[7:0]] <= dma_data_out;

    function automatic void push_xfer(input logic [7:0] page, input int nbytes, input int delay);
        logic [7:0] p;
        p = (page >= 8'hE0) ? page - 8'h20 : page;
        for (int i = 0; i < delay; i++) sb.push_back('{16'h0000, 1'b0, 8'h00});
        for (int i = 0; i < nbytes; i++) begin
            sb.push_back('{{p, 8'(i)}, 1'b0, 8'h00});
            sb.push_back('{16'hFE00 + 16'(i), 1'b1, mem[{p, 8'(i)}]});
        end
    endfunction

    task automatic trigger(input logic [7:0] page);
        @(negedge clock);
        cpu_addr = 16'hFF46;
        cpu_data_out = page;
        cpu_wren = 1'b1;
    endtask

    task automatic test_reset;
        #1 reset = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++;
        if ({dma_active, dma_wren, dma_addr, dma_reg_data} !== 26'd0) begin
            n_fail++;
            $display("FAIL reset_hold: act=%b wren=%b addr=%h reg=%h, want all 0",
                     dma_active, dma_wren, dma_addr, dma_reg_data);
        end
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            n_checks++;
            if ({dma_active, dma_wren, dma_addr, dma_reg_data} !== 26'd0) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d: act=%b wren=%b addr=%h reg=%h, want all 0",
                         c, dma_active, dma_wren, dma_addr, dma_reg_data);
            end
        end
    endtask

    task automatic test_transfer(input string name, input logic [7:0] page);
        exp_t e;
        int k, act, n;
        push_xfer(page, 160, 1);
        n = sb.size();
        trigger(page);
        k = 0;
        act = 0;
        while (sb.size() > 0) begin
            @(negedge clock);
            if (k == 0) cpu_wren = 1'b0;
            e = sb.pop_front();
            n_checks++;
            if (dma_active !== 1'b1 || dma_addr !== e.addr || dma_wren !== e.wren ||
                (e.wren && dma_data_out !== e.data)) begin
                n_fail++;
                $display("FAIL %s cyc %0d: act=%b addr=%h wren=%b data=%h, want act=1 addr=%h wren=%b data=%h",
                         name, k, dma_active, dma_addr, dma_wren, dma_data_out, e.addr, e.wren, e.data);
            end
            act += int'(dma_active);
            k++;
        end
        @(negedge clock);
        n_checks++;
        if (dma_active !== 1'b0 || act != n) begin
            n_fail++;
            $display("FAIL %s_active: active cycles %0d still=%b, want %0d then 0", name, act, dma_active, n);
        end
        n_checks++;
        if (dma_reg_data !== page) begin
            n_fail++;
            $display("FAIL %s_reg: reg=%h, want %h", name, dma_reg_data, page);
        end
    endtask

    task automatic test_oam_contents;
        for (int i = 0; i < 160; i++) begin
            n_checks++;
            if (oam[i] !== (8'(i) ^ 8'h5A)) begin
                n_fail++;
                $display("FAIL oam_copy FE%h: got %h, want %h", 8'(i), oam[i], 8'(i) ^ 8'h5A);
            end
        end
    endtask

    task automatic test_retrigger;
        exp_t e;
        int k, act;
        push_xfer(8'h80, 50, 1);
        push_xfer(8'h81, 160, 1);
        trigger(8'h80);
        k = 0;
        act = 0;
        while (sb.size() > 0) begin
            @(negedge clock);
            if (k == 0 || k == 101) cpu_wren = 1'b0;
            e = sb.pop_front();
            n_checks++;
            if (dma_active !== 1'b1 || dma_addr !== e.addr || dma_wren !== e.wren ||
                (e.wren && dma_data_out !== e.data)) begin
                n_fail++;
                $display("FAIL retrig cyc %0d: act=%b addr=%h wren=%b data=%h, want act=1 addr=%h wren=%b data=%h",
                         k, dma_active, dma_addr, dma_wren, dma_data_out, e.addr, e.wren, e.data);
            end
            act += int'(dma_active);
            if (k == 100) begin
                cpu_data_out = 8'h81;
                cpu_wren = 1'b1;
            end
            k++;
        end
        @(negedge clock);
        n_checks++;
        if (dma_active !== 1'b0 || act != 1 + 2 * 50 + 1 + 320 || dma_reg_data !== 8'h81) begin
            n_fail++;
            $display("FAIL retrig_total: active %0d still=%b reg=%h, want 422 then 0 reg 81",
                     act, dma_active, dma_reg_data);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] keep;
        keep = oam[20];
        trigger(8'hC0);
        for (int k = 0; k <= 41; k++) begin
            @(negedge clock);
            if (k == 0) cpu_wren = 1'b0;
        end
        n_checks++;
        if (dma_addr !== 16'hC014 || dma_wren !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_pos: addr=%h wren=%b, want C014 0", dma_addr, dma_wren);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if ({dma_active, dma_wren, dma_addr, dma_data_out, dma_reg_data} !== 34'd0) begin
            n_fail++;
            $display("FAIL midrst_async: act=%b wren=%b addr=%h data=%h reg=%h, want all 0",
                     dma_active, dma_wren, dma_addr, dma_data_out, dma_reg_data);
        end
        repeat (3) @(negedge clock);
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            n_checks++;
            if ({dma_active, dma_wren, dma_addr} !== 18'd0) begin
                n_fail++;
                $display("FAIL midrst_idle cyc %0d: act=%b wren=%b addr=%h, want 0", c, dma_active, dma_wren, dma_addr);
            end
        end
        n_checks++;
        if (oam[20] !== keep || oam[19] !== mem[16'hC013]) begin
            n_fail++;
            $display("FAIL midrst_oam: FE14=%h FE13=%h, want %h %h", oam[20], oam[19], keep, mem[16'hC013]);
        end
    endtask

    task automatic test_short;
        exp_t e;
        int k;
        sb.push_back('{16'h0000, 1'b0, 8'h00});
        sb.push_back('{16'hFE00, 1'b1, 8'h33});
        @(negedge clock);
        cpu_addr = 16'hFF46;
        cpu_data_out = 8'h00;
        c2_wren = 1'b1;
        k = 0;
        while (sb.size() > 0) begin
            @(negedge clock);
            c2_wren = 1'b0;
            e = sb.pop_front();
            n_checks++;
            if (d2_act !== 1'b1 || d2_addr !== e.addr || d2_wren !== e.wren ||
                (e.wren && d2_dout !== e.data)) begin
                n_fail++;
                $display("FAIL short cyc %0d: act=%b addr=%h wren=%b data=%h, want act=1 addr=%h wren=%b data=%h",
                         k, d2_act, d2_addr, d2_wren, d2_dout, e.addr, e.wren, e.data);
            end
            k++;
        end
        @(negedge clock);
        n_checks++;
        if (d2_act !== 1'b0 || d2_wren !== 1'b0 || dma_active !== 1'b0) begin
            n_fail++;
            $display("FAIL short_end: act=%b wren=%b main=%b, want 0 0 0", d2_act, d2_wren, dma_active);
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'(a) ^ 8'h5A ^ (8'(a >> 8) - 8'hC0);
        for (int a = 0; a < 256; a++) oam[a] = 8'h00;
        test_reset;
        test_transfer("basic", 8'hC0);
        test_oam_contents;
        test_transfer("echo", 8'hE1);
        test_retrigger;
        test_reset_mid;
        test_short;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- Game Boy OAM DMA engine. Sits between the CPU bus and the memory block, in parallel with the CPU as a second bus master.
- Snoops CPU writes to the DMA register (FF46). Then copies LENGTH bytes from page {src,00} into OAM at FE00.
- While active it owns the memory address/write port. The top-level mux selects its bus signals when dma_active is high.

Parameters:
DMA_REG_ADDR, 16'hFF46, register address that triggers a transfer
OAM_BASE, 16'hFE00, destination base address
LENGTH, 160, bytes per transfer (1..256)
START_DELAY, 1, idle cycles between trigger and first read (0..3)

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
cpu_addr  input  16  CPU bus address
cpu_wren  input  1  CPU write strobe
cpu_data_out  input  8  CPU write data
dma_data_in  input  8  memory read data, valid in the same cycle its address is driven
dma_reg_data  output  8  readback value of the DMA register (last written page)
dma_active  output  1  high while the engine owns the bus
dma_addr  output  16  memory address driven by the engine
dma_wren  output  1  memory write strobe
dma_data_out  output  8  memory write data

Behaviour:
- Reset (reset=0, async): state IDLE, idx=0, src_page=0, data_reg=0. All outputs 0 while reset is low. An in-progress transfer is aborted; no further writes are issued.
- Trigger: at a rising edge where cpu_wren=1 and cpu_addr==DMA_REG_ADDR:
  - src_page<=cpu_data_out; dma_reg_data<=cpu_data_out.
  - idx<=0; delay counter<=0; state<=START.
- Source base: {src_page,8'h00}. If src_page>=8'hE0, use {src_page-8'h20,8'h00} (echo-RAM remap).
- FSM states: IDLE, START, READ, WRITE.
  - IDLE: dma_active=0, dma_wren=0, dma_addr=0, dma_data_out=0.
  - START: dma_active=1, dma_wren=0, dma_addr=0. Stays START_DELAY cycles, then goes to READ. With START_DELAY=0, trigger goes directly to READ.
  - READ: dma_active=1, dma_addr=src_base+idx, dma_wren=0. On the edge, data_reg<=dma_data_in; state<=WRITE.
  - WRITE: dma_active=1, dma_addr=OAM_BASE+idx, dma_wren=1, dma_data_out=data_reg. On the edge: if idx==LENGTH-1, state<=IDLE; else idx<=idx+1 and state<=READ.
- Timing: trigger edge T. The first READ cycle starts at T+START_DELAY. Byte i is read in cycle T+START_DELAY+2i and written in the following cycle. dma_active is high for exactly START_DELAY+2*LENGTH cycles (320 cycles + delay at default).
- idx is 8 bits. Address additions are 16-bit with no carry into the page, because idx<=LENGTH-1<=255.
- Retrigger while active: the trigger takes priority over the FSM transition on that edge.
  - Outputs for the current cycle are already driven, so an in-flight WRITE completes.
  - The transfer restarts from idx 0 with the new page via START.
- CPU writes to FF46 while dma_active=1 are still snooped. No other CPU activity affects the engine.
- dma_reg_data holds its value across transfers. It resets only on reset.
- Non-trigger CPU writes to any address, including OAM_BASE, are ignored by this block. Blocking them is the arbiter's job.

Test Plan:
- Reset then idle 10 cycles -> dma_active=0, dma_wren=0, dma_addr=0, dma_reg_data=0 throughout.
- Preload C000..C09F with i^8'h5A; CPU writes 8'hC0 to FF46 -> after START_DELAY=1 cycle:
  - 160 READ/WRITE pairs at C000+i then FE00+i.
  - FE00..FE9F == C000..C09F contents; dma_active high exactly 321 cycles; dma_reg_data=8'hC0.
- Write 8'hE1 to FF46 -> reads issued at C100..C19F (echo remap); writes at FE00..FE9F.
- Start transfer from page 8'h80; at byte 50 write 8'h81 to FF46 -> byte 50 WRITE still issued; restart reads at 8100; total active = 1+2*50+1+320 cycles.
- Pull reset low mid-transfer (byte 20, during READ) -> all outputs 0 immediately (asynchronous); no write at FE14; after reset release the engine remains IDLE.
- LENGTH=1, START_DELAY=0 build; trigger with 8'h00 -> exactly one read at 0000 then one write at FE00; dma_active high 2 cycles.
